// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end sharing one pipelined 64-bit adder among four requesters
module adder_arbiter #(
    parameter int LATENCY = 8,
    parameter int MAX_OUT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         arb_en,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ready,
    input  logic [255:0] req_a,
    input  logic [255:0] req_b,
    output logic [63:0]  add_a,
    output logic [63:0]  add_b,
    input  logic [63:0]  add_sum,
    input  logic         add_c,
    output logic [3:0]   rsp_valid,
    output logic [63:0]  rsp_sum,
    output logic         rsp_c,
    output logic         busy
);
    localparam int DEPTH = 1 + LATENCY;
    logic [1:0]       ptr, gidx;
    logic [3:0]       outstanding [4];
    logic [3:0]       eligible, grant;
    logic [DEPTH-1:0] tag_v;
    logic [1:0]       tag_id [DEPTH];
    // A requester at its limit stays eligible in the cycle its result returns
    always_comb begin
        for (int i = 0; i < 4; i++)
            eligible[i] = req_valid[i] && (outstanding[i] != 4'(MAX_OUT) || rsp_valid[i]);
    end
    always_comb begin
        grant = '0;
        gidx = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (arb_en && eligible[ptr + 2'(k)]) begin
                grant = 4'b1 << (ptr + 2'(k));
                gidx = ptr + 2'(k);
            end
        end
    end
    assign req_ready = reset_n ? grant : '0;
    assign rsp_valid = tag_v[DEPTH-1] ? 4'b1 << tag_id[DEPTH-1] : '0;
    assign rsp_sum = add_sum;
    assign rsp_c = add_c;
    assign busy = |tag_v;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
            add_a <= '0;
            add_b <= '0;
            tag_v <= '0;
            for (int i = 0; i < DEPTH; i++) tag_id[i] <= '0;
            for (int i = 0; i < 4; i++) outstanding[i] <= '0;
        end else begin
            ptr <= |grant ? gidx + 2'd1 : ptr;
            add_a <= |grant ? req_a[64*gidx +: 64] : '0;
            add_b <= |grant ? req_b[64*gidx +: 64] : '0;
            tag_v <= {tag_v[DEPTH-2:0], |grant};
            tag_id[0] <= gidx;
            for (int i = 1; i < DEPTH; i++) tag_id[i] <= tag_id[i-1];
            for (int i = 0; i < 4; i++)
                outstanding[i] <= outstanding[i] + 4'(grant[i]) - 4'(rsp_valid[i]);
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: randomized scoreboard bench for adder_arbiter with a behavioural adder attached
module tb_adder_arbiter;
    localparam int LAT = 8;
    localparam int MAXO = 4;
    typedef struct {int id; logic [64:0] val; int due;} exp_t;
    logic clk = 0, reset_n = 0, arb_en = 0;
    logic [3:0] req_valid = 0;
    logic [255:0] req_a = 0, req_b = 0;
    logic [3:0] req_ready, rsp_valid;
    logic [63:0] add_a, add_b, add_sum, rsp_sum;
    logic add_c, rsp_c, busy;
    logic [64:0] apipe [LAT];
    int cyc = 0, errors = 0, checks = 0;
    int ptr, cnt [4];
    int due_id [int];
    exp_t q [$];

    adder_arbiter #(.LATENCY(LAT), .MAX_OUT(MAXO)) dut (
        .clk(clk), .reset_n(reset_n), .arb_en(arb_en), .req_valid(req_valid),
        .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .add_a(add_a),
        .add_b(add_b), .add_sum(add_sum), .add_c(add_c), .rsp_valid(rsp_valid),
        .rsp_sum(rsp_sum), .rsp_c(rsp_c), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // adder with LAT register stages, sharing clk and reset_n
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LAT; k++) apipe[k] <= '0;
        end else begin
            apipe[0] <= {1'b0, add_a} + {1'b0, add_b};
            for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
        end
    end
    assign add_sum = apipe[LAT-1][63:0];
    assign add_c = apipe[LAT-1][64];

    task automatic check(string name, logic [64:0] got, logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // reference arbiter: predicts grants, counters and busy; pushes expected results
    always @(negedge clk) begin
        int rid, g, i;
        logic bexp;
        if (!reset_n) begin
            ptr = 0;
            for (int k = 0; k < 4; k++) cnt[k] = 0;
            due_id.delete();
            q.delete();
        end else begin
            rid = due_id.exists(cyc) ? due_id[cyc] : -1;
            g = -1;
            for (int k = 0; k < 4; k++) begin
                i = (ptr + k) % 4;
                if (g < 0 && arb_en && req_valid[i] && (cnt[i] < MAXO || rid == i)) g = i;
            end
            check("req_ready", 65'(req_ready), g < 0 ? 65'd0 : 65'(1 << g));
            bexp = 0;
            for (int k = 0; k <= LAT; k++) if (due_id.exists(cyc + k)) bexp = 1;
            check("busy", 65'(busy), 65'(bexp));
            if (rid >= 0) begin
                cnt[rid]--;
                due_id.delete(cyc);
            end
            if (g >= 0) begin
                cnt[g]++;
                ptr = (g + 1) % 4;
                due_id[cyc + 1 + LAT] = g;
                q.push_back('{g, {1'b0, req_a[64*g +: 64]} + {1'b0, req_b[64*g +: 64]}, cyc + 1 + LAT});
            end
        end
    end

    // monitor: pops the scoreboard whenever a result is due
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("rsp_valid", 65'(rsp_valid), 65'(1 << e.id));
                check("rsp_data", {rsp_c, rsp_sum}, e.val);
            end else begin
                check("rsp_idle", 65'(rsp_valid), 65'd0);
            end
        end
    end

    task automatic drive(logic en, logic [3:0] v);
        @(posedge clk);
        #1;
        arb_en = en;
        req_valid = v;
        for (int i = 0; i < 4; i++) begin
            req_a[64*i +: 64] = ($urandom_range(7) == 0) ? '1 : {$urandom, $urandom};
            req_b[64*i +: 64] = ($urandom_range(7) == 0) ? '1 : {$urandom, $urandom};
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ready"}, 65'(req_ready), 65'd0);
        check({tag, "_rsp"}, 65'(rsp_valid), 65'd0);
        check({tag, "_busy"}, 65'(busy), 65'd0);
        check({tag, "_add_a"}, 65'(add_a), 65'd0);
        check({tag, "_add_b"}, 65'(add_b), 65'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        drive(1, 4'b0100);
        req_a[191:128] = '1;
        req_b[191:128] = 64'd1;
        repeat (12) drive(1, 4'b0000);
        repeat (14) drive(1, 4'b0001);
        repeat (12) drive(1, 4'b0000);
        repeat (8) drive(1, 4'b1111);
        repeat (5) drive(1, 4'b1111);
        repeat (15) drive(0, 4'b1111);
        repeat (6) drive(1, 4'b1111);
        @(posedge clk);
        #2 reset_n = 0;
        #1 check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        repeat (3) drive(1, 4'b0110);
        repeat (12) drive(1, 4'b0000);
        repeat (10000) drive($urandom_range(3) != 0, 4'($urandom));
        repeat (20) drive(1, 4'b0000);
        check("drained", 65'(q.size()), 65'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
